// File: rtl/adder_pkg.sv
// adder_pkg: definitions shared by the adder feeder and the adder it drives.
//   - feeder_state_e : sequencing states of the feeder
//   - IDX_*          : operand index values (order of arrival on the stream)
//   - lane_lo/cin_pos: bit positions inside the packed {cin, w, z, y, x} bus
package adder_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    HOLD    = 2'd3
  } feeder_state_e;

  localparam logic [1:0] IDX_X = 2'd0;
  localparam logic [1:0] IDX_Y = 2'd1;
  localparam logic [1:0] IDX_Z = 2'd2;
  localparam logic [1:0] IDX_W = 2'd3;

  // Lowest bit of operand lane 'lane' (0=x .. 3=w) in a bus of w-bit operands.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  // Carry-in sits directly above the four operand lanes.
  function automatic int cin_pos(input int w);
    return 4 * w;
  endfunction

endpackage

// File: rtl/adder_feeder.sv
// adder_feeder: initiator side of the packed-operand adder interface.
// Collects x, y, z, w (and cin with w) from a serial operand stream into the
// packed bus 'ins', lets the adder register its sum, then captures the
// registered sum/zero flag and offers it as a result.
//
// Handshakes (both streams): a transfer happens on a rising clk edge where
// valid and ready are both high. ready never depends on valid; op_ready is
// high only in COLLECT and res_valid only in HOLD, and while res_valid is
// high the res_* fields do not change.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   op_valid/op_ready     operand stream handshake
//   op_data [W-1:0]       operand, order x, y, z, w
//   op_cin                carry-in, taken together with w
//   ins [4W:0]            packed bus to adder {cin, w, z, y, x}
//   sm_r [W+1:0]          registered sum from the adder
//   sm_zero_r             registered zero flag from the adder
//   res_valid/res_ready   result stream handshake
//   res_sum [W+1:0]       captured sum
//   res_zero              captured zero flag
//   res_ovf               captured sum exceeds W bits
//   busy                  not in COLLECT
module adder_feeder
  import adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [W-1:0]   op_data,
  input  logic           op_cin,
  output logic [4*W:0]   ins,
  input  logic [W+1:0]   sm_r,
  input  logic           sm_zero_r,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W+1:0]   res_sum,
  output logic           res_zero,
  output logic           res_ovf,
  output logic           busy
);

  localparam int BUS_W = 4 * W + 1;

  feeder_state_e    state_q, state_d;
  logic [1:0]       idx_q;
  logic [BUS_W-1:0] ins_q, ins_d;
  logic             accept;
  logic [W+1:0]     res_sum_q;
  logic             res_zero_q;
  logic             res_ovf_q;

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      COLLECT: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept = 1'b1;
          if (idx_q == IDX_W) state_d = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;   // adder sum settles and registers at end of this cycle
      WAIT:    state_d = HOLD;   // sm_r valid now; captured at end of this cycle
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // Packed bus with the current operand written into the lane picked by idx.
  always_comb begin
    ins_d = ins_q;
    for (int lane = 0; lane < 4; lane++) begin
      if (idx_q == 2'(lane)) ins_d[lane_lo(lane, W) +: W] = op_data;
    end
    if (idx_q == IDX_W) ins_d[cin_pos(W)] = op_cin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= IDX_X;
      ins_q      <= '0;
      res_sum_q  <= '0;
      res_zero_q <= 1'b0;
      res_ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        idx_q <= idx_q + 2'd1;   // 2-bit index wraps from w back to x
        ins_q <= ins_d;
      end
      if (state_q == WAIT) begin
        res_sum_q  <= sm_r;
        res_zero_q <= sm_zero_r;
        res_ovf_q  <= |sm_r[W+1:W];
      end
    end
  end

  assign ins      = ins_q;
  assign res_sum  = res_sum_q;
  assign res_zero = res_zero_q;
  assign res_ovf  = res_ovf_q;
  assign busy     = (state_q != COLLECT);

endmodule

// File: tb/tb_adder_feeder.sv
module tb_adder_feeder;
  localparam int W  = 8;
  localparam int SW = W + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [W-1:0]  op_data  = '0;
  logic          op_cin   = 1'b0;
  logic [4*W:0]  ins;
  logic [SW-1:0] sm_r;
  logic          sm_zero_r;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [SW-1:0] res_sum;
  logic          res_zero;
  logic          res_ovf;
  logic          busy;

  adder_feeder #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_cin(op_cin),
    .ins(ins), .sm_r(sm_r), .sm_zero_r(sm_zero_r),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_zero(res_zero), .res_ovf(res_ovf), .busy(busy)
  );

  // Stand-in for the adder beside the feeder: one register stage on the packed bus.
  logic [SW-1:0] adder_sum;
  assign adder_sum = SW'(ins[W-1:0]) + SW'(ins[2*W-1:W]) + SW'(ins[3*W-1:2*W])
                   + SW'(ins[4*W-1:3*W]) + SW'(ins[4*W]);
  always @(posedge clk) begin
    sm_r      <= adder_sum;
    sm_zero_r <= (adder_sum == '0);
  end

  // Count operand transfers seen on the stream.
  int accept_cnt = 0;
  always @(posedge clk) if (!rst && op_valid && op_ready) accept_cnt++;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [SW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  int  gap_plan[4];
  bit  use_plan = 1'b0;

  // Offer one operand starting at a negedge; returns at the negedge after it is taken.
  task automatic push_op(input logic [W-1:0] d, input logic c);
    int guard = 0;
    op_valid = 1'b1; op_data = d; op_cin = c;
    while (!op_ready && guard < 50) begin
      @(negedge clk); guard++;
    end
    if (guard >= 50) check_val("op_ready_timeout", 64'(op_ready), 64'd1);
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Reference: plain arithmetic on the operand set.
  task automatic run_set(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d,
                         input logic ci, input int max_gap, input int hold_cycles,
                         input bit abort_in_hold);
    logic [W-1:0]  ops[4];
    logic [4*W:0]  exp_ins;
    logic [SW-1:0] exp_sum;
    int            total;
    int            base;
    int            gap;
    ops     = '{a, b, c, d};
    total   = int'(a) + int'(b) + int'(c) + int'(d) + int'(ci);
    exp_ins = {ci, d, c, b, a};
    exp_q.push_back(SW'(total));
    base    = accept_cnt;

    for (int i = 0; i < 4; i++) begin
      gap = use_plan ? gap_plan[i] : int'($urandom_range(0, max_gap));
      repeat (gap) begin
        op_valid = 1'b0; op_data = W'($urandom); op_cin = 1'($urandom);
        res_ready = 1'($urandom);  // no effect outside HOLD
        @(negedge clk);
      end
      push_op(ops[i], (i == 3) ? ci : 1'($urandom));
    end

    // ISSUE
    check_val("accepts", 64'(accept_cnt - base), 64'd4);
    check_val("ins_packed", 64'(ins), 64'(exp_ins));
    check_val("issue_op_ready", 64'(op_ready), 64'd0);
    check_val("issue_busy", 64'(busy), 64'd1);
    check_val("issue_res_valid", 64'(res_valid), 64'd0);
    op_valid = 1'b1; op_data = W'($urandom); res_ready = 1'($urandom);
    @(negedge clk);
    // WAIT
    check_val("wait_res_valid", 64'(res_valid), 64'd0);
    check_val("wait_op_ready", 64'(op_ready), 64'd0);
    op_data = W'($urandom); res_ready = 1'b0;
    @(negedge clk);
    // HOLD: result appears 2 cycles after the 4th accept
    exp_sum = exp_q.pop_front();
    check_val("hold_res_valid", 64'(res_valid), 64'd1);
    check_val("res_sum", 64'(res_sum), 64'(exp_sum));
    check_val("res_zero", 64'(res_zero), 64'(total == 0));
    check_val("res_ovf", 64'(res_ovf), 64'(total >= (1 << W)));

    if (abort_in_hold) begin
      op_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_val("rst_hold_res_valid", 64'(res_valid), 64'd0);
      check_val("rst_hold_ins", 64'(ins), 64'd0);
      check_val("rst_hold_res_sum", 64'(res_sum), 64'd0);
      check_val("rst_hold_flags", 64'({res_zero, res_ovf, busy}), 64'd0);
      check_val("rst_hold_op_ready", 64'(op_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    for (int k = 0; k < hold_cycles; k++) begin
      op_data = W'($urandom);  // op_valid still high: must be ignored in HOLD
      @(negedge clk);
      check_val("stall_res_valid", 64'(res_valid), 64'd1);
      check_val("stall_res_sum", 64'(res_sum), 64'(exp_sum));
      check_val("stall_op_ready", 64'(op_ready), 64'd0);
      check_val("stall_ins", 64'(ins), 64'(exp_ins));
    end

    op_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_val("done_op_ready", 64'(op_ready), 64'd1);
    check_val("done_busy", 64'(busy), 64'd0);
    check_val("done_res_valid", 64'(res_valid), 64'd0);
    check_val("done_accepts", 64'(accept_cnt - base), 64'd4);
    check_val("done_ins", 64'(ins), 64'(exp_ins));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("reset_op_ready", 64'(op_ready), 64'd1);
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_res_valid", 64'(res_valid), 64'd0);
    check_val("reset_ins", 64'(ins), 64'd0);
    check_val("reset_res", 64'({res_sum, res_zero, res_ovf}), 64'd0);

    // Directed sets
    run_set(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 0, 0, 1'b0);
    run_set(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1, 1'b0);
    run_set(8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 0, 2, 1'b0);

    // op_valid pattern 1,0,0,1,1,0,1 and a 5-cycle HOLD stall
    gap_plan = '{0, 2, 0, 1};
    use_plan = 1'b1;
    run_set(8'd10, 8'd20, 8'd30, 8'd40, 1'b0, 0, 5, 1'b0);
    use_plan = 1'b0;

    // Reset in the middle of collection
    push_op(8'd77, 1'b1);
    push_op(8'd99, 1'b1);
    rst = 1'b1;
    #1;
    check_val("rst_mid_ins", 64'(ins), 64'd0);
    check_val("rst_mid_op_ready", 64'(op_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_set(8'd5, 8'd6, 8'd7, 8'd8, 1'b0, 1, 1, 1'b0);

    // Reset while a result is pending, then a set as after power-up
    run_set(8'd100, 8'd50, 8'd25, 8'd12, 1'b1, 0, 0, 1'b1);
    run_set(8'd9, 8'd8, 8'd7, 8'd6, 1'b1, 0, 0, 1'b0);

    // Randomized sets
    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] r[4];
      int mode;
      mode = int'($urandom_range(0, 5));
      for (int i = 0; i < 4; i++) begin
        if (mode == 0)      r[i] = '0;
        else if (mode == 1) r[i] = '1;
        else                r[i] = W'($urandom);
      end
      run_set(r[0], r[1], r[2], r[3], 1'($urandom), 3, int'($urandom_range(0, 4)), 1'b0);
    end

    check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
